// File: rtl/dispatch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dispatch_unit_pkg
// Brief   : Shared width defaults and opcode constants for the dispatch slice.
// Revision: 1.0 - initial release
// ============================================================================
package dispatch_unit_pkg;

    localparam int c_XLEN_DEF  = 32;
    localparam int c_ROB_W_DEF = 4;
    localparam int c_REG_W_DEF = 5;
    localparam int c_OP_W_DEF  = 6;
    localparam int c_CDB_N_DEF = 2;

    // Opcode value the decoder emits for a bubble; dispatch swallows it.
    localparam int c_OP_NOP    = 0;

endpackage
`default_nettype wire

// File: rtl/dispatch_unit_operand_resolve.sv
`default_nettype none
// ============================================================================
// Module  : operand_resolve
// Brief   : Source-operand resolution at capture plus CDB snoop of a waiting tag.
// Revision: 1.0 - initial release
// ============================================================================
module operand_resolve
    import dispatch_unit_pkg::*;
#(
    parameter int XLEN  = c_XLEN_DEF,
    parameter int ROB_W = c_ROB_W_DEF,
    parameter int CDB_N = c_CDB_N_DEF
) (
    input  logic                   i_rf_busy,
    input  logic [XLEN-1:0]        i_rf_value,
    input  logic [ROB_W-1:0]       i_rf_tag,
    input  logic                   i_rob_ready,
    input  logic [XLEN-1:0]        i_rob_value,
    input  logic [CDB_N-1:0]       i_cdb_valid,
    input  logic [CDB_N*ROB_W-1:0] i_cdb_tag,
    input  logic [CDB_N*XLEN-1:0]  i_cdb_value,
    input  logic [XLEN-1:0]        i_stage_v,
    input  logic [ROB_W-1:0]       i_stage_q,
    output logic [XLEN-1:0]        o_cap_v,
    output logic [ROB_W-1:0]       o_cap_q,
    output logic [XLEN-1:0]        o_live_v,
    output logic [ROB_W-1:0]       o_live_q
);

    logic            w_cap_hit;
    logic [XLEN-1:0] w_cap_cdb_v;
    logic            w_live_hit;
    logic [XLEN-1:0] w_live_cdb_v;

    // Scan from the top channel down so the lowest matching index wins.
    always_comb begin
        w_cap_hit    = 1'b0;
        w_cap_cdb_v  = '0;
        w_live_hit   = 1'b0;
        w_live_cdb_v = '0;
        for (int i = CDB_N - 1; i >= 0; i--) begin
            if (i_cdb_valid[i] && (i_cdb_tag[i*ROB_W +: ROB_W] == i_rf_tag)) begin
                w_cap_hit   = 1'b1;
                w_cap_cdb_v = i_cdb_value[i*XLEN +: XLEN];
            end
            if (i_cdb_valid[i] && (i_cdb_tag[i*ROB_W +: ROB_W] == i_stage_q)) begin
                w_live_hit   = 1'b1;
                w_live_cdb_v = i_cdb_value[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        o_cap_v = '0;
        o_cap_q = '0;
        if (!i_rf_busy) begin
            o_cap_v = i_rf_value;
        end else if (w_cap_hit) begin
            o_cap_v = w_cap_cdb_v;
        end else if (i_rob_ready) begin
            o_cap_v = i_rob_value;
        end else begin
            o_cap_q = i_rf_tag;
        end
    end

    // Tag 0 means already resolved, so it must never pick up a broadcast.
    always_comb begin
        o_live_v = i_stage_v;
        o_live_q = i_stage_q;
        if ((i_stage_q != '0) && w_live_hit) begin
            o_live_v = w_live_cdb_v;
            o_live_q = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module  : dispatch_unit
// Brief   : Single-entry dispatch stage: ROB allocate, rename, operand capture.
// Revision: 1.0 - initial release
// ============================================================================
module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter int XLEN  = c_XLEN_DEF,
    parameter int ROB_W = c_ROB_W_DEF,
    parameter int REG_W = c_REG_W_DEF,
    parameter int OP_W  = c_OP_W_DEF,
    parameter int CDB_N = c_CDB_N_DEF
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   dec_valid_in,
    output logic                   dec_ready_out,
    input  logic [OP_W-1:0]        dec_opcode_in,
    input  logic [REG_W-1:0]       dec_rs_in,
    input  logic [REG_W-1:0]       dec_rt_in,
    input  logic [REG_W-1:0]       dec_rd_in,
    input  logic [XLEN-1:0]        dec_imm_in,
    input  logic [XLEN-1:0]        dec_pc_in,
    input  logic                   bp_taken_in,
    output logic [REG_W-1:0]       rf_rs_out,
    output logic [REG_W-1:0]       rf_rt_out,
    input  logic                   rf_rs_busy_in,
    input  logic                   rf_rt_busy_in,
    input  logic [XLEN-1:0]        rf_rs_value_in,
    input  logic [XLEN-1:0]        rf_rt_value_in,
    input  logic [ROB_W-1:0]       rf_rs_tag_in,
    input  logic [ROB_W-1:0]       rf_rt_tag_in,
    output logic                   rf_rename_en_out,
    output logic [REG_W-1:0]       rf_rename_reg_out,
    output logic [ROB_W-1:0]       rf_rename_tag_out,
    input  logic                   rob_full_in,
    input  logic [ROB_W-1:0]       rob_tag_in,
    output logic [ROB_W-1:0]       rob_rs_tag_out,
    output logic [ROB_W-1:0]       rob_rt_tag_out,
    input  logic                   rob_rs_ready_in,
    input  logic                   rob_rt_ready_in,
    input  logic [XLEN-1:0]        rob_rs_value_in,
    input  logic [XLEN-1:0]        rob_rt_value_in,
    output logic                   rob_en_out,
    output logic [OP_W-1:0]        rob_opcode_out,
    output logic [REG_W-1:0]       rob_dest_out,
    output logic [XLEN-1:0]        rob_pc_out,
    output logic                   rob_taken_out,
    input  logic [CDB_N-1:0]       cdb_valid_in,
    input  logic [CDB_N*ROB_W-1:0] cdb_tag_in,
    input  logic [CDB_N*XLEN-1:0]  cdb_value_in,
    input  logic                   rs_ready_in,
    output logic                   rs_en_out,
    output logic [OP_W-1:0]        rs_opcode_out,
    output logic [XLEN-1:0]        rs_vj_out,
    output logic [XLEN-1:0]        rs_vk_out,
    output logic [ROB_W-1:0]       rs_qj_out,
    output logic [ROB_W-1:0]       rs_qk_out,
    output logic [XLEN-1:0]        rs_a_out,
    output logic [XLEN-1:0]        rs_pc_out,
    output logic [ROB_W-1:0]       rs_dest_out,
    input  logic                   flush_in
);

    logic             r_valid;
    logic [OP_W-1:0]  r_opcode;
    logic [XLEN-1:0]  r_vj;
    logic [XLEN-1:0]  r_vk;
    logic [ROB_W-1:0] r_qj;
    logic [ROB_W-1:0] r_qk;
    logic [XLEN-1:0]  r_imm;
    logic [XLEN-1:0]  r_pc;
    logic [ROB_W-1:0] r_dest;

    logic             w_ready;
    logic             w_accept;
    logic             w_is_nop;
    logic             w_load;
    logic             w_drain;
    logic [XLEN-1:0]  w_cap_vj;
    logic [XLEN-1:0]  w_cap_vk;
    logic [ROB_W-1:0] w_cap_qj;
    logic [ROB_W-1:0] w_cap_qk;
    logic [XLEN-1:0]  w_live_vj;
    logic [XLEN-1:0]  w_live_vk;
    logic [ROB_W-1:0] w_live_qj;
    logic [ROB_W-1:0] w_live_qk;

    // rst_n_in gating keeps every enable low for the whole reset window.
    assign w_ready  = rst_n_in & rdy_in & ~flush_in & ~rob_full_in & (~r_valid | rs_ready_in);
    assign w_accept = w_ready & dec_valid_in;
    assign w_is_nop = (dec_opcode_in == OP_W'(c_OP_NOP));
    assign w_load   = w_accept & ~w_is_nop;
    assign w_drain  = rst_n_in & r_valid & rs_ready_in & rdy_in & ~flush_in;

    assign dec_ready_out     = w_ready;

    assign rf_rs_out         = dec_rs_in;
    assign rf_rt_out         = dec_rt_in;
    assign rob_rs_tag_out    = rf_rs_tag_in;
    assign rob_rt_tag_out    = rf_rt_tag_in;

    assign rf_rename_en_out  = w_load & (dec_rd_in != '0);
    assign rf_rename_reg_out = dec_rd_in;
    assign rf_rename_tag_out = rob_tag_in;

    assign rob_en_out        = w_load;
    assign rob_opcode_out    = dec_opcode_in;
    assign rob_dest_out      = dec_rd_in;
    assign rob_pc_out        = dec_pc_in;
    assign rob_taken_out     = bp_taken_in;

    // Operands go out through the snoop path so a same-cycle broadcast is not lost on drain.
    assign rs_en_out         = w_drain;
    assign rs_opcode_out     = r_opcode;
    assign rs_vj_out         = w_live_vj;
    assign rs_vk_out         = w_live_vk;
    assign rs_qj_out         = w_live_qj;
    assign rs_qk_out         = w_live_qk;
    assign rs_a_out          = r_imm;
    assign rs_pc_out         = r_pc;
    assign rs_dest_out       = r_dest;

    operand_resolve #(
        .XLEN  (XLEN),
        .ROB_W (ROB_W),
        .CDB_N (CDB_N)
    ) u_resolve_j (
        .i_rf_busy   (rf_rs_busy_in),
        .i_rf_value  (rf_rs_value_in),
        .i_rf_tag    (rf_rs_tag_in),
        .i_rob_ready (rob_rs_ready_in),
        .i_rob_value (rob_rs_value_in),
        .i_cdb_valid (cdb_valid_in),
        .i_cdb_tag   (cdb_tag_in),
        .i_cdb_value (cdb_value_in),
        .i_stage_v   (r_vj),
        .i_stage_q   (r_qj),
        .o_cap_v     (w_cap_vj),
        .o_cap_q     (w_cap_qj),
        .o_live_v    (w_live_vj),
        .o_live_q    (w_live_qj)
    );

    operand_resolve #(
        .XLEN  (XLEN),
        .ROB_W (ROB_W),
        .CDB_N (CDB_N)
    ) u_resolve_k (
        .i_rf_busy   (rf_rt_busy_in),
        .i_rf_value  (rf_rt_value_in),
        .i_rf_tag    (rf_rt_tag_in),
        .i_rob_ready (rob_rt_ready_in),
        .i_rob_value (rob_rt_value_in),
        .i_cdb_valid (cdb_valid_in),
        .i_cdb_tag   (cdb_tag_in),
        .i_cdb_value (cdb_value_in),
        .i_stage_v   (r_vk),
        .i_stage_q   (r_qk),
        .o_cap_v     (w_cap_vk),
        .o_cap_q     (w_cap_qk),
        .o_live_v    (w_live_vk),
        .o_live_q    (w_live_qk)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_valid  <= 1'b0;
            r_opcode <= '0;
            r_vj     <= '0;
            r_vk     <= '0;
            r_qj     <= '0;
            r_qk     <= '0;
            r_imm    <= '0;
            r_pc     <= '0;
            r_dest   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid  <= 1'b1;
                r_opcode <= dec_opcode_in;
                r_vj     <= w_cap_vj;
                r_vk     <= w_cap_vk;
                r_qj     <= w_cap_qj;
                r_qk     <= w_cap_qk;
                r_imm    <= dec_imm_in;
                r_pc     <= dec_pc_in;
                r_dest   <= rob_tag_in;
            end else begin
                if (w_drain) begin
                    r_valid <= 1'b0;
                end
                if (r_valid) begin
                    r_vj <= w_live_vj;
                    r_vk <= w_live_vk;
                    r_qj <= w_live_qj;
                    r_qk <= w_live_qk;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_dispatch_unit
// Brief   : Directed self-checking bench for dispatch_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dispatch_unit;

    localparam int XLEN  = 32;
    localparam int ROB_W = 4;
    localparam int REG_W = 5;
    localparam int OP_W  = 6;
    localparam int CDB_N = 2;

    logic                   clk_in = 1'b0;
    logic                   rst_n_in = 1'b0;
    logic                   rdy_in = 1'b0;
    logic                   dec_valid_in = 1'b0;
    logic                   dec_ready_out;
    logic [OP_W-1:0]        dec_opcode_in = '0;
    logic [REG_W-1:0]       dec_rs_in = '0;
    logic [REG_W-1:0]       dec_rt_in = '0;
    logic [REG_W-1:0]       dec_rd_in = '0;
    logic [XLEN-1:0]        dec_imm_in = '0;
    logic [XLEN-1:0]        dec_pc_in = '0;
    logic                   bp_taken_in = 1'b0;
    logic [REG_W-1:0]       rf_rs_out;
    logic [REG_W-1:0]       rf_rt_out;
    logic                   rf_rs_busy_in = 1'b0;
    logic                   rf_rt_busy_in = 1'b0;
    logic [XLEN-1:0]        rf_rs_value_in = '0;
    logic [XLEN-1:0]        rf_rt_value_in = '0;
    logic [ROB_W-1:0]       rf_rs_tag_in = '0;
    logic [ROB_W-1:0]       rf_rt_tag_in = '0;
    logic                   rf_rename_en_out;
    logic [REG_W-1:0]       rf_rename_reg_out;
    logic [ROB_W-1:0]       rf_rename_tag_out;
    logic                   rob_full_in = 1'b0;
    logic [ROB_W-1:0]       rob_tag_in = '0;
    logic [ROB_W-1:0]       rob_rs_tag_out;
    logic [ROB_W-1:0]       rob_rt_tag_out;
    logic                   rob_rs_ready_in = 1'b0;
    logic                   rob_rt_ready_in = 1'b0;
    logic [XLEN-1:0]        rob_rs_value_in = '0;
    logic [XLEN-1:0]        rob_rt_value_in = '0;
    logic                   rob_en_out;
    logic [OP_W-1:0]        rob_opcode_out;
    logic [REG_W-1:0]       rob_dest_out;
    logic [XLEN-1:0]        rob_pc_out;
    logic                   rob_taken_out;
    logic [CDB_N-1:0]       cdb_valid_in = '0;
    logic [CDB_N*ROB_W-1:0] cdb_tag_in = '0;
    logic [CDB_N*XLEN-1:0]  cdb_value_in = '0;
    logic                   rs_ready_in = 1'b0;
    logic                   rs_en_out;
    logic [OP_W-1:0]        rs_opcode_out;
    logic [XLEN-1:0]        rs_vj_out;
    logic [XLEN-1:0]        rs_vk_out;
    logic [ROB_W-1:0]       rs_qj_out;
    logic [ROB_W-1:0]       rs_qk_out;
    logic [XLEN-1:0]        rs_a_out;
    logic [XLEN-1:0]        rs_pc_out;
    logic [ROB_W-1:0]       rs_dest_out;
    logic                   flush_in = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    dispatch_unit #(
        .XLEN  (XLEN),
        .ROB_W (ROB_W),
        .REG_W (REG_W),
        .OP_W  (OP_W),
        .CDB_N (CDB_N)
    ) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .rdy_in            (rdy_in),
        .dec_valid_in      (dec_valid_in),
        .dec_ready_out     (dec_ready_out),
        .dec_opcode_in     (dec_opcode_in),
        .dec_rs_in         (dec_rs_in),
        .dec_rt_in         (dec_rt_in),
        .dec_rd_in         (dec_rd_in),
        .dec_imm_in        (dec_imm_in),
        .dec_pc_in         (dec_pc_in),
        .bp_taken_in       (bp_taken_in),
        .rf_rs_out         (rf_rs_out),
        .rf_rt_out         (rf_rt_out),
        .rf_rs_busy_in     (rf_rs_busy_in),
        .rf_rt_busy_in     (rf_rt_busy_in),
        .rf_rs_value_in    (rf_rs_value_in),
        .rf_rt_value_in    (rf_rt_value_in),
        .rf_rs_tag_in      (rf_rs_tag_in),
        .rf_rt_tag_in      (rf_rt_tag_in),
        .rf_rename_en_out  (rf_rename_en_out),
        .rf_rename_reg_out (rf_rename_reg_out),
        .rf_rename_tag_out (rf_rename_tag_out),
        .rob_full_in       (rob_full_in),
        .rob_tag_in        (rob_tag_in),
        .rob_rs_tag_out    (rob_rs_tag_out),
        .rob_rt_tag_out    (rob_rt_tag_out),
        .rob_rs_ready_in   (rob_rs_ready_in),
        .rob_rt_ready_in   (rob_rt_ready_in),
        .rob_rs_value_in   (rob_rs_value_in),
        .rob_rt_value_in   (rob_rt_value_in),
        .rob_en_out        (rob_en_out),
        .rob_opcode_out    (rob_opcode_out),
        .rob_dest_out      (rob_dest_out),
        .rob_pc_out        (rob_pc_out),
        .rob_taken_out     (rob_taken_out),
        .cdb_valid_in      (cdb_valid_in),
        .cdb_tag_in        (cdb_tag_in),
        .cdb_value_in      (cdb_value_in),
        .rs_ready_in       (rs_ready_in),
        .rs_en_out         (rs_en_out),
        .rs_opcode_out     (rs_opcode_out),
        .rs_vj_out         (rs_vj_out),
        .rs_vk_out         (rs_vk_out),
        .rs_qj_out         (rs_qj_out),
        .rs_qk_out         (rs_qk_out),
        .rs_a_out          (rs_a_out),
        .rs_pc_out         (rs_pc_out),
        .rs_dest_out       (rs_dest_out),
        .flush_in          (flush_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_dec(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rs,
                             input logic [REG_W-1:0] rt, input logic [REG_W-1:0] rd,
                             input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc,
                             input logic [ROB_W-1:0] tag);
        dec_opcode_in = op;
        dec_rs_in     = rs;
        dec_rt_in     = rt;
        dec_rd_in     = rd;
        dec_imm_in    = imm;
        dec_pc_in     = pc;
        rob_tag_in    = tag;
    endtask

    task automatic clear_sources;
        rf_rs_busy_in   = 1'b0;
        rf_rt_busy_in   = 1'b0;
        rob_rs_ready_in = 1'b0;
        rob_rt_ready_in = 1'b0;
        cdb_valid_in    = '0;
        cdb_tag_in      = '0;
        cdb_value_in    = '0;
    endtask

    initial begin
        // Reset with everything asking to move
        rdy_in       = 1'b1;
        rs_ready_in  = 1'b1;
        drive_dec(6'h08, 5'd1, 5'd2, 5'd5, 32'h10, 32'h100, 4'd3);
        dec_valid_in = 1'b1;
        #1;
        check("rst_dec_ready", dec_ready_out, 0);
        check("rst_rob_en", rob_en_out, 0);
        check("rst_rename_en", rf_rename_en_out, 0);
        check("rst_rs_en", rs_en_out, 0);
        step;
        step;
        check("rst_rs_opcode", rs_opcode_out, 0);
        rst_n_in = 1'b1;

        // Capture from regfile, ROB allocate and rename
        rs_ready_in    = 1'b0;
        rf_rs_value_in = 32'd5;
        rf_rt_value_in = 32'd7;
        #1;
        check("a_dec_ready", dec_ready_out, 1);
        check("a_rob_en", rob_en_out, 1);
        check("a_rob_opcode", rob_opcode_out, 6'h08);
        check("a_rob_dest", rob_dest_out, 5);
        check("a_rob_pc", rob_pc_out, 32'h100);
        check("a_rename_en", rf_rename_en_out, 1);
        check("a_rename_reg", rf_rename_reg_out, 5);
        check("a_rename_tag", rf_rename_tag_out, 3);
        check("a_rf_rs", rf_rs_out, 1);
        check("a_rs_en_empty", rs_en_out, 0);
        step;
        dec_valid_in = 1'b0;
        #1;
        check("a_vj", rs_vj_out, 5);
        check("a_qj", rs_qj_out, 0);
        check("a_vk", rs_vk_out, 7);
        check("a_dest", rs_dest_out, 3);
        check("a_imm", rs_a_out, 32'h10);
        check("a_pc", rs_pc_out, 32'h100);
        check("a_rs_en_stall", rs_en_out, 0);
        rs_ready_in = 1'b1;
        #1;
        check("a_rs_en", rs_en_out, 1);
        check("a_dec_ready_drain", dec_ready_out, 1);
        rdy_in = 1'b0;
        #1;
        check("frz_rs_en", rs_en_out, 0);
        check("frz_dec_ready", dec_ready_out, 0);
        step;
        rdy_in = 1'b1;
        #1;
        check("frz_held", rs_en_out, 1);
        step;
        check("a_drained", rs_en_out, 0);

        // Busy source resolved by CDB ch1; other source from ROB
        drive_dec(6'h09, 5'd3, 5'd4, 5'd6, 32'h0, 32'h104, 4'd4);
        rs_ready_in     = 1'b0;
        rf_rs_busy_in   = 1'b1;
        rf_rs_tag_in    = 4'd2;
        rf_rt_busy_in   = 1'b1;
        rf_rt_tag_in    = 4'd7;
        rob_rt_ready_in = 1'b1;
        rob_rt_value_in = 32'h55;
        cdb_valid_in    = 2'b10;
        cdb_tag_in      = {4'd2, 4'd0};
        cdb_value_in    = {32'h77, 32'h0};
        dec_valid_in    = 1'b1;
        #1;
        check("b_rob_rs_tag", rob_rs_tag_out, 2);
        check("b_rob_rt_tag", rob_rt_tag_out, 7);
        step;
        dec_valid_in = 1'b0;
        clear_sources;
        #1;
        check("b_vj", rs_vj_out, 32'h77);
        check("b_qj", rs_qj_out, 0);
        check("b_vk", rs_vk_out, 32'h55);
        check("b_qk", rs_qk_out, 0);
        check("b_full_not_ready", dec_ready_out, 0);

        // Back-to-back drain plus accept; lowest CDB channel wins; qk waits
        drive_dec(6'h0A, 5'd8, 5'd9, 5'd7, 32'h0, 32'h108, 4'd5);
        rf_rs_busy_in = 1'b1;
        rf_rs_tag_in  = 4'd6;
        rf_rt_busy_in = 1'b1;
        rf_rt_tag_in  = 4'd4;
        cdb_valid_in  = 2'b11;
        cdb_tag_in    = {4'd6, 4'd6};
        cdb_value_in  = {32'h22, 32'h11};
        rs_ready_in   = 1'b1;
        dec_valid_in  = 1'b1;
        #1;
        check("c_rs_en_b2b", rs_en_out, 1);
        check("c_rob_en_b2b", rob_en_out, 1);
        check("c_old_vj", rs_vj_out, 32'h77);
        step;
        dec_valid_in = 1'b0;
        rs_ready_in  = 1'b0;
        clear_sources;
        #1;
        check("c_opcode", rs_opcode_out, 6'h0A);
        check("c_vj_low_ch", rs_vj_out, 32'h11);
        check("c_qj", rs_qj_out, 0);
        check("c_qk_wait", rs_qk_out, 4);
        check("c_rs_en_stall", rs_en_out, 0);
        cdb_valid_in = 2'b01;
        cdb_tag_in   = {4'd0, 4'd4};
        cdb_value_in = {32'h0, 32'h9};
        #1;
        check("c_live_qk", rs_qk_out, 0);
        check("c_live_vk", rs_vk_out, 9);
        step;
        clear_sources;
        #1;
        check("c_snoop_qk", rs_qk_out, 0);
        check("c_snoop_vk", rs_vk_out, 9);
        rs_ready_in = 1'b1;
        #1;
        check("c_rs_en", rs_en_out, 1);

        // ROB full blocks allocate; stage still drains
        rob_full_in = 1'b1;
        drive_dec(6'h0B, 5'd1, 5'd1, 5'd8, 32'h0, 32'h10C, 4'd6);
        dec_valid_in = 1'b1;
        #1;
        check("d_dec_ready", dec_ready_out, 0);
        check("d_rob_en", rob_en_out, 0);
        check("d_rename_en", rf_rename_en_out, 0);
        check("d_rs_en", rs_en_out, 1);
        step;
        dec_valid_in = 1'b0;
        rob_full_in  = 1'b0;
        #1;
        check("d_drained", rs_en_out, 0);

        // Flush during accept with a full stage
        drive_dec(6'h0C, 5'd1, 5'd1, 5'd9, 32'h0, 32'h110, 4'd7);
        rs_ready_in  = 1'b0;
        dec_valid_in = 1'b1;
        step;
        drive_dec(6'h0D, 5'd1, 5'd1, 5'd10, 32'h0, 32'h114, 4'd8);
        rs_ready_in = 1'b1;
        flush_in    = 1'b1;
        #1;
        check("e_rob_en", rob_en_out, 0);
        check("e_rename_en", rf_rename_en_out, 0);
        check("e_rs_en", rs_en_out, 0);
        check("e_dec_ready", dec_ready_out, 0);
        step;
        flush_in     = 1'b0;
        dec_valid_in = 1'b0;
        #1;
        check("e_flushed", rs_en_out, 0);

        // rd = x0: allocate but no rename; async reset mid-stall
        drive_dec(6'h0E, 5'd1, 5'd1, 5'd0, 32'h0, 32'h118, 4'd9);
        rs_ready_in  = 1'b0;
        dec_valid_in = 1'b1;
        #1;
        check("f_rob_en", rob_en_out, 1);
        check("f_rename_en", rf_rename_en_out, 0);
        step;
        dec_valid_in = 1'b0;
        #1;
        check("f_opcode", rs_opcode_out, 6'h0E);
        rs_ready_in = 1'b1;
        #1;
        check("f_rs_en_pre", rs_en_out, 1);
        rst_n_in = 1'b0;
        #1;
        check("f_rst_opcode", rs_opcode_out, 0);
        check("f_rst_rs_en", rs_en_out, 0);
        check("f_rst_dec_ready", dec_ready_out, 0);
        step;
        rst_n_in = 1'b1;

        // NOP is accepted and dropped
        drive_dec(6'h00, 5'd1, 5'd1, 5'd3, 32'h0, 32'h11C, 4'd10);
        dec_valid_in = 1'b1;
        #1;
        check("g_nop_ready", dec_ready_out, 1);
        check("g_nop_rob_en", rob_en_out, 0);
        check("g_nop_rename", rf_rename_en_out, 0);
        step;
        dec_valid_in = 1'b0;
        #1;
        check("g_nop_no_stage", rs_en_out, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
